// File: rtl/rv_stream_arbiter_if.sv
// Handshake bundle between NUM_REQS upstream streams and one downstream sink.
// The arbiter sits on the slave side; the environment drives the master side.
interface rv_stream_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 8
);
  localparam int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0]       ready_in;
  logic                      valid_out;
  logic [DATAW-1:0]          data_out;
  logic [SELW-1:0]           sel_out;
  logic                      ready_out;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, sel_out
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, sel_out
  );
endinterface

// File: rtl/rv_stream_arbiter.sv
// Round-robin arbiter merging NUM_REQS ready/valid streams into one,
// with an optional single-entry registered output stage.
module rv_stream_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 8,
  parameter int BUFFERED = 1
) (
  input logic                  clk,
  input logic                  reset,
  rv_stream_arbiter_if.slave   bus
);
  localparam int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [SELW-1:0]     r_last;
  logic [SELW-1:0]     w_grant;
  logic                w_anyValid;
  logic                w_canAccept;
  logic                w_fire;
  logic [DATAW-1:0]    w_data;
  logic [NUM_REQS-1:0] w_readyIn;

  function automatic logic [SELW-1:0] wrapIdx(input int base, input int off);
    return SELW'((base + off) % NUM_REQS);
  endfunction

  // Walk from the farthest candidate back to the nearest so the nearest valid one wins.
  always_comb begin
    w_grant = '0;
    if (NUM_REQS > 1) begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        if (bus.valid_in[wrapIdx(int'(r_last), k + 1)]) begin
          w_grant = wrapIdx(int'(r_last), k + 1);
        end
      end
    end
  end

  assign w_anyValid = |bus.valid_in;
  assign w_fire     = w_anyValid & w_canAccept & ~reset;

  always_comb begin
    w_data = bus.data_in[int'(w_grant)*DATAW +: DATAW];
  end

  always_comb begin
    w_readyIn = '0;
    if (w_fire) begin
      w_readyIn[w_grant] = 1'b1;
    end
  end

  assign bus.ready_in = w_readyIn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= SELW'(NUM_REQS - 1);
    end else if (w_fire) begin
      r_last <= w_grant;
    end
  end

  generate
    if (BUFFERED != 0) begin : g_buffered
      logic             r_valid;
      logic [DATAW-1:0] r_data;
      logic [SELW-1:0]  r_sel;

      // A pop and a load can share a cycle, keeping one transfer per clock.
      assign w_canAccept = ~r_valid | bus.ready_out;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_sel   <= '0;
        end else if (w_fire) begin
          r_valid <= 1'b1;
          r_data  <= w_data;
          r_sel   <= w_grant;
        end else if (bus.ready_out) begin
          r_valid <= 1'b0;
        end
      end

      assign bus.valid_out = r_valid;
      assign bus.data_out  = r_data;
      assign bus.sel_out   = r_sel;
    end else begin : g_passthrough
      assign w_canAccept   = bus.ready_out;
      assign bus.valid_out = w_anyValid;
      assign bus.data_out  = w_data;
      assign bus.sel_out   = w_grant;
    end
  endgenerate
endmodule

// File: doc/rv_stream_arbiter.md
RV_STREAM_ARBITER -- requirements
Module: RV_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of input streams (>=1).
REQ-002 SHALL have parameter DATAW, default 8, payload width per stream.
REQ-003 SHALL have parameter BUFFERED, default 1, 1 = registered output stage, 0 = combinational pass-through.
REQ-004 SHALL have localparam SELW = max(1, $clog2(NUM_REQS)).
REQ-005 SHALL be clocked by a single clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 valid_in  input  NUM_REQS  per-stream request (typically !empty of an upstream queue).
REQ-009 data_in  input  NUM_REQS*DATAW  packed payloads, stream i at bits [i*DATAW +: DATAW].
REQ-010 ready_in  output  NUM_REQS  per-stream accept (typically drives pop of an upstream queue); one-hot or zero.
REQ-011 valid_out  output  1  output payload valid.
REQ-012 data_out  output  DATAW  selected payload.
REQ-013 sel_out  output  SELW  index of stream that supplied data_out.
REQ-014 ready_out  input  1  downstream accept.

Function
REQ-015 SHALL transfer on input i when valid_in[i] & ready_in[i]; on output when valid_out & ready_out.
REQ-016 SHALL arbitrate round-robin: priority search starts at index (last_r+1) mod NUM_REQS and wraps; grant = first index with valid_in set.
REQ-017 SHALL update last_r to the granted index only on an input transfer; otherwise last_r holds.
REQ-018 SHALL assert ready_in[i] only for the granted index, and only when the output can accept (see REQ-020/REQ-023); never when valid_in[i]=0.
REQ-019 BUFFERED=1: SHALL hold one output entry {valid_out_r, data_out_r, sel_out_r}.
REQ-020 BUFFERED=1: output can accept when !valid_out_r | ready_out; same-cycle output pop and input load SHALL sustain one transfer per cycle.
REQ-021 BUFFERED=1: on input transfer, register loads data_in[grant], sel_out=grant, valid_out=1 next cycle (latency 1 cycle).
REQ-022 BUFFERED=1: on output transfer with no input transfer, valid_out SHALL go 0; while valid_out & !ready_out, data_out and sel_out SHALL be stable.
REQ-023 BUFFERED=0: valid_out = |valid_in, data_out = data_in[grant], sel_out = grant, ready_in[grant] = ready_out, all combinational (latency 0).
REQ-024 NUM_REQS==1: SHALL bypass arbitration; grant fixed 0, sel_out always 0.
REQ-025 SHALL not drop, duplicate or reorder payloads of any single stream.
REQ-026 SHALL guarantee no stream with continuously asserted valid_in waits more than NUM_REQS-1 grants to other streams (given ready_out eventually asserts).
REQ-027 Changes of valid_in while not granted SHALL not affect last_r.

Reset
REQ-028 On reset: last_r = NUM_REQS-1 (stream 0 highest priority first).
REQ-029 On reset (BUFFERED=1): valid_out=0, data_out=0, sel_out=0; ready_in SHALL be 0 during the reset cycle.
REQ-030 Reset mid-transfer SHALL discard the buffered entry; no input transfer occurs in the reset cycle.

Verification
REQ-031 Reset, valid_in=4'b1111, ready_out=1, BUFFERED=1 -> sel_out sequence 0,1,2,3,0 starting cycle after first grant, one per cycle.
REQ-032 valid_in=4'b0101 constant, ready_out=1 -> grants alternate 0,2,0,2; ready_in[1], ready_in[3] never asserted.
REQ-033 valid_in=4'b0001, data 8'hA5, ready_out=0 for 5 cycles -> valid_out=1, data_out=8'hA5 stable, ready_in=0 after first load; ready_out=1 -> single transfer, no duplicate.
REQ-034 Back-to-back stream 2 only (payloads 1..10), ready_out toggling randomly -> output exactly 1..10 in order, sel_out=2.
REQ-035 BUFFERED=0, valid_in=4'b1000, ready_out=1 -> same-cycle valid_out=1, data_out=data_in[3], ready_in=4'b1000.
REQ-036 Reset asserted while valid_out=1 and ready_out=0 -> next cycle valid_out=0, sel_out=0, next grant goes to lowest valid index.
